// File: rtl/usb_pkg.sv
// Shared USB host definitions: token PIDs, speed encodings and the SOF
// generator state encoding.
package usb_pkg;

  localparam logic [7:0] PID_SOF       = 8'hA5;

  localparam logic [1:0] SPEED_UNKNOWN = 2'b00;
  localparam logic [1:0] SPEED_FULL    = 2'b01;
  localparam logic [1:0] SPEED_HIGH    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PID    = 3'd1,
    ST_FRM_LO = 3'd2,
    ST_FRM_HI = 3'd3,
    ST_WAIT   = 3'd4
  } sof_state_e;

  // 11 is reserved and behaves like an unknown speed.
  function automatic logic speed_is_valid(input logic [1:0] speed);
    return (speed == SPEED_FULL) || (speed == SPEED_HIGH);
  endfunction

endpackage

// File: rtl/usb_crc5.sv
// Token CRC5 over an 11-bit field (x^5+x^2+1, init all ones, LSB first).
// crc is the complemented residual, bit 4 is the first bit on the wire.
module usb_crc5 (
  input  logic [10:0] data,
  output logic [4:0]  crc
);

  logic [4:0] lfsr_s;
  logic       fb_s;

  // Unrolled serial LFSR over the eleven token bits.
  always_comb begin
    lfsr_s = 5'b11111;
    fb_s   = 1'b0;
    for (int i = 0; i < 11; i++) begin
      fb_s   = data[i] ^ lfsr_s[4];
      lfsr_s = {lfsr_s[3:0], 1'b0} ^ (fb_s ? 5'b00101 : 5'b00000);
    end
    crc = ~lfsr_s;
  end

endmodule

// File: rtl/usb_sof_generator.sv
// Host Start-of-Frame generator: frame/microframe counters, SOF token
// emission towards the UTMI TX arbiter and the end-of-frame guard flag.
module usb_sof_generator
  import usb_pkg::*;
#(
  parameter int unsigned FS_FRAME_CYCLES  = 60000,
  parameter int unsigned HS_UFRAME_CYCLES = 7500,
  parameter int unsigned EOF_GUARD_CYCLES = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  detected_speed,
  input  logic        reset_active,
  input  logic        sof_enable,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic [10:0] frame_number,
  output logic [2:0]  microframe,
  output logic        sof_strobe,
  output logic        eof_window,
  output logic        sof_missed
);

  sof_state_e  state_r;
  logic [15:0] timer_r;
  logic [1:0]  speed_r;
  logic [10:0] tok_frame_r;

  logic        active_s;
  logic        speed_change_s;
  logic        boundary_s;
  logic        capture_s;
  logic [15:0] period_s;
  logic [15:0] eof_start_s;
  logic [15:0] timer_nxt_s;
  logic [10:0] tok_src_s;
  logic [4:0]  crc_s;
  logic [4:0]  crc_field_s;

  usb_crc5 u_crc5 (
    .data (tok_frame_r),
    .crc  (crc_s)
  );

  // Activity, period selection, boundary detection and token source.
  always_comb begin
    active_s       = sof_enable && !reset_active && speed_is_valid(detected_speed);
    speed_change_s = (detected_speed != speed_r);
    if (speed_r == SPEED_HIGH) begin
      period_s = 16'(HS_UFRAME_CYCLES);
    end else begin
      period_s = 16'(FS_FRAME_CYCLES);
    end
    eof_start_s = period_s - 16'(EOF_GUARD_CYCLES);
    boundary_s  = (timer_r == (period_s - 16'd1));
    if (boundary_s) begin
      timer_nxt_s = 16'd0;
    end else begin
      timer_nxt_s = timer_r + 16'd1;
    end
    // The token frame is latched on the first PID cycle so a pending token
    // survives a missed boundary with its original contents.
    capture_s = (state_r == ST_PID) && sof_strobe && !sof_missed;
    if (capture_s) begin
      tok_src_s = frame_number;
    end else begin
      tok_src_s = tok_frame_r;
    end
    crc_field_s = {crc_s[0], crc_s[1], crc_s[2], crc_s[3], crc_s[4]};
  end

  // SOF state machine, timer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      timer_r      <= 16'd0;
      speed_r      <= SPEED_UNKNOWN;
      tok_frame_r  <= 11'd0;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      tx_last      <= 1'b0;
      frame_number <= 11'd0;
      microframe   <= 3'd0;
      sof_strobe   <= 1'b0;
      eof_window   <= 1'b0;
      sof_missed   <= 1'b0;
    end else begin
      sof_strobe <= 1'b0;
      sof_missed <= 1'b0;
      if (capture_s) begin
        tok_frame_r <= frame_number;
      end
      if (state_r == ST_IDLE) begin
        if (active_s) begin
          state_r      <= ST_PID;
          timer_r      <= 16'd0;
          speed_r      <= detected_speed;
          frame_number <= 11'd0;
          microframe   <= 3'd0;
          tx_data      <= PID_SOF;
          tx_valid     <= 1'b1;
          tx_last      <= 1'b0;
          sof_strobe   <= 1'b1;
          eof_window   <= 1'b0;
        end
      end else if (!active_s || speed_change_s) begin
        state_r    <= ST_IDLE;
        tx_data    <= 8'h00;
        tx_valid   <= 1'b0;
        tx_last    <= 1'b0;
        eof_window <= 1'b0;
      end else begin
        timer_r    <= timer_nxt_s;
        eof_window <= (timer_nxt_s >= eof_start_s);
        if (boundary_s) begin
          sof_strobe <= 1'b1;
          if (state_r != ST_WAIT) begin
            sof_missed <= 1'b1;
          end
          if (speed_r == SPEED_HIGH) begin
            microframe <= microframe + 3'd1;
            if (microframe == 3'd7) begin
              frame_number <= frame_number + 11'd1;
            end
          end else begin
            frame_number <= frame_number + 11'd1;
          end
        end
        case (state_r)
          ST_PID: begin
            if (tx_ready) begin
              state_r <= ST_FRM_LO;
              tx_data <= tok_src_s[7:0];
            end
          end
          ST_FRM_LO: begin
            if (tx_ready) begin
              state_r <= ST_FRM_HI;
              tx_data <= {crc_field_s, tok_frame_r[10:8]};
              tx_last <= 1'b1;
            end
          end
          ST_FRM_HI: begin
            if (tx_ready) begin
              state_r  <= ST_WAIT;
              tx_data  <= 8'h00;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (boundary_s) begin
              state_r  <= ST_PID;
              tx_data  <= PID_SOF;
              tx_valid <= 1'b1;
              tx_last  <= 1'b0;
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_sof_generator.sv
// Directed bench for usb_sof_generator: token bytes, CRC, backpressure,
// overrun, wrap, EOF window, deactivation and speed change.
module tb_usb_sof_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  detected_speed;
  logic        reset_active;
  logic        sof_enable;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;
  logic [10:0] frame_number;
  logic [2:0]  microframe;
  logic        sof_strobe;
  logic        eof_window;
  logic        sof_missed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  usb_sof_generator dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .detected_speed (detected_speed),
    .reset_active   (reset_active),
    .sof_enable     (sof_enable),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_last        (tx_last),
    .tx_ready       (tx_ready),
    .frame_number   (frame_number),
    .microframe     (microframe),
    .sof_strobe     (sof_strobe),
    .eof_window     (eof_window),
    .sof_missed     (sof_missed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; detected_speed = 2'b00; reset_active = 1'b0;
    sof_enable = 1'b0; tx_ready = 1'b1;
    ticks(3);
    total++;
    if ({tx_valid, tx_last, tx_data, sof_strobe, eof_window, sof_missed} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h",
               {tx_valid, tx_last, tx_data, sof_strobe, eof_window, sof_missed}, 13'd0);
    end
    total++;
    if ({frame_number, microframe} !== 14'd0) begin
      bad++; $display("FAIL reset_counters got=%h exp=%h", {frame_number, microframe}, 14'd0);
    end
    rst_n = 1'b1;
    ticks(2);
    total++;
    if (tx_valid !== 1'b0) begin
      bad++; $display("FAIL idle_disabled_valid got=%b exp=0", tx_valid);
    end
  endtask

  task automatic test_hs_steady();
    detected_speed = 2'b10; sof_enable = 1'b1;
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h2A5 || frame_number !== 11'd0 || microframe !== 3'd0) begin
      bad++; $display("FAIL hs_first_pid got=%h/%h/%h exp=2a5/000/0",
                      {tx_valid, tx_last, tx_data}, frame_number, microframe);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h200) begin
      bad++; $display("FAIL hs_frm_lo got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h200);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h310) begin
      bad++; $display("FAIL hs_frm_hi got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h310);
    end
    tick();
    total++;
    if ({tx_valid, tx_last} !== 2'b00) begin
      bad++; $display("FAIL hs_token_end got=%b exp=00", {tx_valid, tx_last});
    end
    ticks(6896);
    total++;
    if (eof_window !== 1'b0) begin
      bad++; $display("FAIL hs_eof_before got=%b exp=0", eof_window);
    end
    tick();
    total++;
    if (eof_window !== 1'b1) begin
      bad++; $display("FAIL hs_eof_start got=%b exp=1", eof_window);
    end
    ticks(599);
    total++;
    if (tx_valid !== 1'b0 || eof_window !== 1'b1) begin
      bad++; $display("FAIL hs_before_second_pid got=%b%b exp=01", tx_valid, eof_window);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h2A5 || sof_strobe !== 1'b1 ||
        microframe !== 3'd1 || eof_window !== 1'b0) begin
      bad++; $display("FAIL hs_second_pid got=%h/%b/%h/%b exp=2a5/1/1/0",
                      {tx_valid, tx_last, tx_data}, sof_strobe, microframe, eof_window);
    end
  endtask

  task automatic test_overrun();
    int missed_cnt;
    int missed_at;
    int unstable;
    int stray_valid;
    missed_cnt = 0; missed_at = -1; unstable = 0; stray_valid = 0;
    tx_ready = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      tick();
      if (sof_missed === 1'b1) begin
        missed_cnt++;
        missed_at = i;
      end
      if ({tx_valid, tx_last, tx_data} !== 10'h2A5) unstable++;
    end
    tx_ready = 1'b1;
    total++;
    if (missed_cnt != 1 || missed_at != 7499) begin
      bad++; $display("FAIL overrun_missed got=%0d@%0d exp=1@7499", missed_cnt, missed_at);
    end
    total++;
    if (unstable != 0) begin
      bad++; $display("FAIL overrun_pid_hold got=%0d exp=0", unstable);
    end
    total++;
    if (microframe !== 3'd2) begin
      bad++; $display("FAIL overrun_microframe got=%0d exp=2", microframe);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h200) begin
      bad++; $display("FAIL overrun_frm_lo got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h200);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h310) begin
      bad++; $display("FAIL overrun_frm_hi got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h310);
    end
    force dut.microframe = 3'd7;
    tick();
    release dut.microframe;
    total++;
    if ({tx_valid, tx_last} !== 2'b00) begin
      bad++; $display("FAIL overrun_token_end got=%b exp=00", {tx_valid, tx_last});
    end
    for (int i = 0; i < 6996; i++) begin
      tick();
      if (tx_valid !== 1'b0) stray_valid++;
    end
    total++;
    if (stray_valid != 0) begin
      bad++; $display("FAIL overrun_no_extra_token got=%0d exp=0", stray_valid);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h2A5 || sof_strobe !== 1'b1 || sof_missed !== 1'b0 ||
        frame_number !== 11'd1 || microframe !== 3'd0) begin
      bad++; $display("FAIL frame_advance got=%h/%b%b/%h/%h exp=2a5/10/001/0",
                      {tx_valid, tx_last, tx_data}, sof_strobe, sof_missed, frame_number, microframe);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h201) begin
      bad++; $display("FAIL frame1_lo got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h201);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h3E8) begin
      bad++; $display("FAIL frame1_crc got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h3E8);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int held_bad;
    held_bad = 0;
    sof_enable = 1'b0;
    tick();
    total++;
    if ({tx_valid, tx_last, eof_window} !== 3'b000 || frame_number !== 11'd1) begin
      bad++; $display("FAIL disable_hold got=%b/%h exp=000/001",
                      {tx_valid, tx_last, eof_window}, frame_number);
    end
    sof_enable = 1'b1;
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h2A5 || frame_number !== 11'd0) begin
      bad++; $display("FAIL reenable_pid got=%h/%h exp=2a5/000", {tx_valid, tx_last, tx_data}, frame_number);
    end
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({tx_valid, tx_last, tx_data} !== 10'h200) held_bad++;
    end
    tx_ready = 1'b1;
    total++;
    if (held_bad != 0) begin
      bad++; $display("FAIL backpressure_hold got=%0d exp=0", held_bad);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h310) begin
      bad++; $display("FAIL backpressure_next got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h310);
    end
    tick();
  endtask

  task automatic test_reset_mid_token();
    sof_enable = 1'b0;
    tick();
    sof_enable = 1'b1;
    ticks(2);
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h200) begin
      bad++; $display("FAIL midtoken_frm_lo got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h200);
    end
    reset_active = 1'b1;
    tick();
    total++;
    if ({tx_valid, tx_last} !== 2'b00) begin
      bad++; $display("FAIL midtoken_drop got=%b exp=00", {tx_valid, tx_last});
    end
    tick();
    total++;
    if (tx_valid !== 1'b0) begin
      bad++; $display("FAIL midtoken_idle got=%b exp=0", tx_valid);
    end
    reset_active = 1'b0;
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h2A5 || frame_number !== 11'd0) begin
      bad++; $display("FAIL midtoken_restart got=%h/%h exp=2a5/000", {tx_valid, tx_last, tx_data}, frame_number);
    end
    ticks(3);
  endtask

  task automatic test_crc_vector();
    sof_enable = 1'b0;
    tick();
    force dut.frame_number = 11'h710;
    sof_enable = 1'b1;
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h2A5) begin
      bad++; $display("FAIL crc_pid got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h2A5);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h210) begin
      bad++; $display("FAIL crc_frm_lo got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h210);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h32F) begin
      bad++; $display("FAIL crc_frm_hi got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h32F);
    end
    tick();
    sof_enable = 1'b0;
    tick();
    release dut.frame_number;
  endtask

  task automatic test_fs_wrap();
    detected_speed = 2'b01; sof_enable = 1'b1;
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h2A5 || frame_number !== 11'd0 || microframe !== 3'd0) begin
      bad++; $display("FAIL fs_first_pid got=%h/%h/%h exp=2a5/000/0",
                      {tx_valid, tx_last, tx_data}, frame_number, microframe);
    end
    ticks(3);
    force dut.frame_number = 11'h7FF;
    tick();
    release dut.frame_number;
    ticks(59395);
    total++;
    if (eof_window !== 1'b0) begin
      bad++; $display("FAIL fs_eof_before got=%b exp=0", eof_window);
    end
    tick();
    total++;
    if (eof_window !== 1'b1) begin
      bad++; $display("FAIL fs_eof_start got=%b exp=1", eof_window);
    end
    ticks(599);
    total++;
    if (eof_window !== 1'b1 || tx_valid !== 1'b0 || frame_number !== 11'h7FF) begin
      bad++; $display("FAIL fs_last_cycle got=%b%b/%h exp=10/7ff", eof_window, tx_valid, frame_number);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h2A5 || sof_strobe !== 1'b1 ||
        frame_number !== 11'h000 || microframe !== 3'd0 || eof_window !== 1'b0) begin
      bad++; $display("FAIL fs_wrap got=%h/%b/%h/%h/%b exp=2a5/1/000/0/0",
                      {tx_valid, tx_last, tx_data}, sof_strobe, frame_number, microframe, eof_window);
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h200) begin
      bad++; $display("FAIL fs_wrap_lo got=%h exp=%h", {tx_valid, tx_last, tx_data}, 10'h200);
    end
  endtask

  task automatic test_speed_change();
    detected_speed = 2'b10;
    tick();
    total++;
    if ({tx_valid, tx_last} !== 2'b00) begin
      bad++; $display("FAIL speed_change_idle got=%b exp=00", {tx_valid, tx_last});
    end
    tick();
    total++;
    if ({tx_valid, tx_last, tx_data} !== 10'h2A5 || frame_number !== 11'd0 || microframe !== 3'd0) begin
      bad++; $display("FAIL speed_change_restart got=%h/%h/%h exp=2a5/000/0",
                      {tx_valid, tx_last, tx_data}, frame_number, microframe);
    end
    ticks(3);
  endtask

  initial begin
    test_reset();
    test_hs_steady();
    test_overrun();
    test_backpressure();
    test_reset_mid_token();
    test_crc_vector();
    test_fs_wrap();
    test_speed_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
